id_ex_pipe: RTL
===============

Name: id_ex_pipe

Overview:
- Parametrised ID/EX pipeline register for the MIPS core. It is the successor to the fixed-width decode/execute latch.
- Adds a valid bit, external stall (hold), flush (bubble on taken branch/jump), and built-in load-use hazard detection with one-cycle bubble insertion.
- Adds a saturating bubble counter for performance monitoring.
- Sits between the DECODE stage (control unit, register file, sign extender) and the EXECUTE stage (ALU, forwarding unit).

Parameters:
DATA_W, 32, width of npc, read data and sign-extended immediate
REG_W, 5, register-specifier width (rs/rt/rd)
WB_W, 2, WB control field width
M_W, 3, MEM control field width
EX_W, 4, EX control field width
MEMREAD_BIT, 1, index of the MemRead bit inside the M control field
CNT_W, 16, bubble counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall_in  in  1  hold all stage contents (downstream stall)
flush  in  1  squash the instruction entering EX (branch/jump taken)
valid_in  in  1  IF/ID holds a real instruction
ctlwb_out  in  WB_W  WB control from the control unit
ctlm_out  in  M_W  MEM control
ctlex_out  in  EX_W  EX control
npc, readdat1, readdat2, signext_out  in  DATA_W each  decode data
instr_2521, instr_2016, instr_1511  in  REG_W each  rs, rt, rd
wb_ctlout, m_ctlout, ex_ctlout  out  WB_W/M_W/EX_W  registered control
npcout, rdata1out, rdata2out, s_extendout  out  DATA_W each  registered data
instrout_2521, instrout_2016, instrout_1511  out  REG_W each  registered rs, rt, rd
valid_out  out  1  EX stage holds a real instruction
hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle
bubble_cnt  out  CNT_W  count of bubbles inserted

Behaviour:
- Reset: all outputs are 0, including valid_out and bubble_cnt. hazard_stall is 0 because it depends on valid_out.
- Load-use detection, combinational:
  - hz = valid_out & m_ctlout[MEMREAD_BIT] & valid_in & (instrout_2016 != 0) & ((instrout_2016 == instr_2521) | (instrout_2016 == instr_2016)).
  - Register 0 never raises a hazard.
- hazard_stall = hz & ~flush & ~rst.
- Per-edge priority (highest first):
  1. rst: clear everything.
  2. flush: bubble.
  3. stall_in: hold every output register unchanged, including valid_out. bubble_cnt unchanged.
  4. hz: bubble.
  5. Otherwise load: every output takes its input, and valid_out <= valid_in.
- Bubble:
  - All control outputs, all data outputs, all register-specifier outputs and valid_out <= 0.
  - bubble_cnt increments by 1.
- Latency: 1 cycle from input to output on a load.
- A hazard bubble lasts exactly one cycle. After it, valid_out = 0, so hz drops and the stalled consumer loads on the next edge.
- Flush while hz is true: flush wins and hazard_stall is forced to 0, because the IF/ID contents are also being discarded.
- stall_in while hz is true: hold wins. hazard_stall stays asserted, which is harmless because upstream is held anyway. No bubble is counted.
- bubble_cnt saturates at 2^CNT_W - 1 and does not wrap.
- valid_in = 0 on a load gives valid_out = 0. Other fields are captured as presented. This is not counted as a bubble.
- All outputs are driven only from registers, except hazard_stall.
- No latches and no initial blocks; reset alone defines the start state.

Test Plan:
- Reset held for 2 cycles with random inputs -> every output is 0; bubble_cnt = 0; hazard_stall = 0.
- Load: npc = 0x00000010, readdat1 = 0x12345678, ctlex_out = 4'b1100, valid_in = 1 -> these values appear on the outputs one edge later; valid_out = 1.
- Load-use: an lw with m_ctlout[1] = 1 and rt = 8 is in EX. Decode presents rs = 8.
  - Required: hazard_stall = 1.
  - Next edge: all control = 0, valid_out = 0, bubble_cnt = 1.
  - Following edge: the add loads normally.
- No false hazard: lw with rt = 0 in EX and decode rs = 0 -> hazard_stall = 0; normal load.
- Priority: flush = 1 and stall_in = 1 with hz true -> bubble; hazard_stall = 0; bubble_cnt increments. With stall_in = 1 only -> outputs unchanged across 3 edges.
- Saturation with CNT_W = 2: 5 consecutive flushes -> bubble_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_pipe.sv
// id_ex_pipe
//   ID/EX pipeline register for the MIPS core. It adds these features to the basic latch:
//   - a valid bit,
//   - a downstream hold (stall_in),
//   - a squash on a taken branch or jump (flush),
//   - load-use hazard detection that inserts a one-cycle bubble,
//   - a saturating counter of inserted bubbles.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   stall_in         hold every register, including valid_out and bubble_cnt
//   flush            load a bubble in place of the decode instruction
//   valid_in         IF/ID holds a real instruction
//   ctl*_out, npc, readdat1/2, signext_out, instr_*
//                    decode-stage control, data and register specifiers
//   wb/m/ex_ctlout, npcout, rdata1/2out, s_extendout, instrout_*
//                    registered copies of the decode-stage fields
//   valid_out        EX holds a real instruction
//   hazard_stall     combinational; freezes PC and IF/ID for this cycle
//   bubble_cnt       saturating count of bubbles (flush or hazard)
module id_ex_pipe #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int WB_W        = 2,
    parameter int M_W         = 3,
    parameter int EX_W        = 4,
    parameter int MEMREAD_BIT = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [WB_W-1:0]   ctlwb_out,
    input  logic [M_W-1:0]    ctlm_out,
    input  logic [EX_W-1:0]   ctlex_out,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] readdat1,
    input  logic [DATA_W-1:0] readdat2,
    input  logic [DATA_W-1:0] signext_out,
    input  logic [REG_W-1:0]  instr_2521,
    input  logic [REG_W-1:0]  instr_2016,
    input  logic [REG_W-1:0]  instr_1511,
    output logic [WB_W-1:0]   wb_ctlout,
    output logic [M_W-1:0]    m_ctlout,
    output logic [EX_W-1:0]   ex_ctlout,
    output logic [DATA_W-1:0] npcout,
    output logic [DATA_W-1:0] rdata1out,
    output logic [DATA_W-1:0] rdata2out,
    output logic [DATA_W-1:0] s_extendout,
    output logic [REG_W-1:0]  instrout_2521,
    output logic [REG_W-1:0]  instrout_2016,
    output logic [REG_W-1:0]  instrout_1511,
    output logic              valid_out,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic hz;
    logic bubble;

    // A valid load in EX whose destination (rt) is a source of the decode
    // instruction. $zero is never a real dependency.
    always_comb begin
        hz = valid_out & m_ctlout[MEMREAD_BIT] & valid_in
           & (instrout_2016 != '0)
           & ((instrout_2016 == instr_2521) | (instrout_2016 == instr_2016));
    end

    // Flush discards IF/ID as well, so there is nothing to freeze.
    assign hazard_stall = hz & ~flush & ~rst;

    // A flush always makes a bubble. A hazard makes a bubble only when the
    // stage is not held.
    assign bubble = flush | (~stall_in & hz);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ctlout     <= '0;
            m_ctlout      <= '0;
            ex_ctlout     <= '0;
            npcout        <= '0;
            rdata1out     <= '0;
            rdata2out     <= '0;
            s_extendout   <= '0;
            instrout_2521 <= '0;
            instrout_2016 <= '0;
            instrout_1511 <= '0;
            valid_out     <= 1'b0;
            bubble_cnt    <= '0;
        end else if (bubble) begin
            wb_ctlout     <= '0;
            m_ctlout      <= '0;
            ex_ctlout     <= '0;
            npcout        <= '0;
            rdata1out     <= '0;
            rdata2out     <= '0;
            s_extendout   <= '0;
            instrout_2521 <= '0;
            instrout_2016 <= '0;
            instrout_1511 <= '0;
            valid_out     <= 1'b0;
            if (bubble_cnt != {CNT_W{1'b1}})
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end else if (!stall_in) begin
            wb_ctlout     <= ctlwb_out;
            m_ctlout      <= ctlm_out;
            ex_ctlout     <= ctlex_out;
            npcout        <= npc;
            rdata1out     <= readdat1;
            rdata2out     <= readdat2;
            s_extendout   <= signext_out;
            instrout_2521 <= instr_2521;
            instrout_2016 <= instr_2016;
            instrout_1511 <= instr_1511;
            valid_out     <= valid_in;
        end
    end

endmodule
